// File: rtl/ps2_game_input_ctrl.sv
// PS/2 scan-code decoder for game controls: tracks E0/F0 prefixes, keeps held-key
// flags, and produces move levels, rate-limited fire pulses and a pause toggle.
module ps2_game_input_ctrl #(
  parameter logic [7:0] KEY_LEFT       = 8'h1C,
  parameter logic [7:0] KEY_RIGHT      = 8'h23,
  parameter logic [7:0] KEY_FIRE       = 8'h29,
  parameter logic [7:0] KEY_PAUSE      = 8'h4D,
  parameter int         FIRE_GAP       = 5000000,
  parameter int         PREFIX_TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic [7:0] last_code
);

  localparam int CW = $clog2(FIRE_GAP) + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          lp_q, lp_d, le_q, le_d, rp_q, rp_d, re_q, re_d;
  logic          fire_held_q, fire_held_d, pause_held_q, pause_held_d;
  logic          pause_q, pause_d, fire_q, fire_d;
  logic          ml_q, ml_d, mr_q, mr_d;
  logic [7:0]    last_q, last_d;
  logic          is_make, is_brk, ext, left_any, right_any;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    lp_d         = lp_q;
    le_d         = le_q;
    rp_d         = rp_q;
    re_d         = re_q;
    fire_held_d  = fire_held_q;
    pause_held_d = pause_held_q;
    pause_d      = pause_q;
    last_d       = last_q;
    is_make      = 1'b0;
    is_brk       = 1'b0;
    ext          = 1'b0;

    // A strobe always wins over a coincident timeout: it is decoded in the current state.
    if (ps2_key_pressed) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (ps2_key_data == 8'hE0)      state_d = EXT;
          else if (ps2_key_data == 8'hF0) state_d = BRK;
          else                            is_make = 1'b1;
        end
        EXT: begin
          if (ps2_key_data == 8'hF0)      state_d = EXT_BRK;
          else if (ps2_key_data != 8'hE0) begin
            is_make = 1'b1;
            ext     = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          is_brk  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          is_brk  = 1'b1;
          ext     = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Setting an already-set flag is a no-op, so typematic repeats fall out naturally.
    if (is_make || is_brk) begin
      if (!ext && ps2_key_data == KEY_LEFT)  lp_d = is_make;
      if ( ext && ps2_key_data == 8'h6B)     le_d = is_make;
      if (!ext && ps2_key_data == KEY_RIGHT) rp_d = is_make;
      if ( ext && ps2_key_data == 8'h74)     re_d = is_make;
      if (!ext && ps2_key_data == KEY_FIRE)  fire_held_d = is_make;
      if (!ext && ps2_key_data == KEY_PAUSE) begin
        pause_held_d = is_make;
        if (is_make && !pause_held_q) pause_d = ~pause_q;
      end
    end
    if (is_make) last_d = ext ? (ps2_key_data | 8'h80) : ps2_key_data;

    left_any  = lp_d | le_d;
    right_any = rp_d | re_d;
    ml_d      = left_any & ~right_any & ~pause_d;
    mr_d      = right_any & ~left_any & ~pause_d;

    fire_d = fire_held_q && (cool_q == '0) && !pause_q;
    if (fire_d)              cool_d = CW'(FIRE_GAP - 1);
    else if (cool_q != '0)   cool_d = cool_q - 1'b1;
    else                     cool_d = cool_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      cool_q       <= '0;
      lp_q         <= 1'b0;
      le_q         <= 1'b0;
      rp_q         <= 1'b0;
      re_q         <= 1'b0;
      fire_held_q  <= 1'b0;
      pause_held_q <= 1'b0;
      pause_q      <= 1'b0;
      fire_q       <= 1'b0;
      ml_q         <= 1'b0;
      mr_q         <= 1'b0;
      last_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cool_q       <= cool_d;
      lp_q         <= lp_d;
      le_q         <= le_d;
      rp_q         <= rp_d;
      re_q         <= re_d;
      fire_held_q  <= fire_held_d;
      pause_held_q <= pause_held_d;
      pause_q      <= pause_d;
      fire_q       <= fire_d;
      ml_q         <= ml_d;
      mr_q         <= mr_d;
      last_q       <= last_d;
    end
  end

  assign move_left  = ml_q;
  assign move_right = mr_q;
  assign fire       = fire_q;
  assign pause      = pause_q;
  assign last_code  = last_q;

endmodule

// File: tb/tb_ps2_game_input_ctrl.sv
// Directed bench: stimulus pushes hand-computed expected outputs per cycle into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_ps2_game_input_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       move_left, move_right, fire, pause;
  logic [7:0] last_code;

  ps2_game_input_ctrl #(
    .FIRE_GAP(4),
    .PREFIX_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data),
    .move_left(move_left),
    .move_right(move_right),
    .fire(fire),
    .pause(pause),
    .last_code(last_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       ml, mr, f, p;
    logic [7:0] lc;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if ({move_left, move_right, fire, pause, last_code} !== {e.ml, e.mr, e.f, e.p, e.lc}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got ml=%b mr=%b fire=%b pause=%b last=%h, want ml=%b mr=%b fire=%b pause=%b last=%h",
                 e.name, cyc, move_left, move_right, fire, pause, last_code,
                 e.ml, e.mr, e.f, e.p, e.lc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-cycle strobe; data is scrambled afterwards since it must be ignored.
  task automatic send(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    idle(1);
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'($urandom);
  endtask

  task automatic expect_now(input logic ml, input logic mr, input logic f, input logic p,
                            input logic [7:0] lc, input string name);
    exp_t x;
    x.cyc = cyc; x.ml = ml; x.mr = mr; x.f = f; x.p = p; x.lc = lc; x.name = name;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00;
    idle(2);
    expect_now(0, 0, 0, 0, 8'h00, "reset_state");
    idle(1);
    reset = 1'b0;
    idle(2);

    // Plain left make / break
    send(8'h1C); expect_now(1, 0, 0, 0, 8'h1C, "left_make");
    send(8'hF0); expect_now(1, 0, 0, 0, 8'h1C, "left_brk_prefix");
    send(8'h1C); expect_now(0, 0, 0, 0, 8'h1C, "left_break");

    // Extended left, conflicting right, right release
    send(8'hE0); expect_now(0, 0, 0, 0, 8'h1C, "ext_prefix");
    send(8'h6B); expect_now(1, 0, 0, 0, 8'hEB, "ext_left_make");
    send(8'h23); expect_now(0, 0, 0, 0, 8'h23, "conflict");
    send(8'hF0); expect_now(0, 0, 0, 0, 8'h23, "conflict_brk_prefix");
    send(8'h23); expect_now(1, 0, 0, 0, 8'h23, "right_release");
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_now(0, 0, 0, 0, 8'h23, "ext_left_break");

    // Fire held: pulses at +1, +5, +9, then released before the next pulse is due
    send(8'h29); expect_now(0, 0, 0, 0, 8'h29, "fire_make");
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      expect_now(0, 0, (i % 4) == 1, 0, 8'h29, "fire_cadence");
    end
    send(8'hF0); expect_now(0, 0, 0, 0, 8'h29, "fire_brk_prefix");
    send(8'h29); expect_now(0, 0, 0, 0, 8'h29, "fire_break");
    for (int i = 0; i < 6; i++) begin
      idle(1);
      expect_now(0, 0, 0, 0, 8'h29, "fire_after_release");
    end

    // Pause toggle, typematic repeat, and suppression while paused
    send(8'h4D); expect_now(0, 0, 0, 1, 8'h4D, "pause_on");
    send(8'h4D); expect_now(0, 0, 0, 1, 8'h4D, "pause_repeat");
    send(8'hF0); send(8'h4D); expect_now(0, 0, 0, 1, 8'h4D, "pause_break");
    send(8'h29); expect_now(0, 0, 0, 1, 8'h29, "paused_fire_make");
    for (int i = 0; i < 6; i++) begin
      idle(1);
      expect_now(0, 0, 0, 1, 8'h29, "paused_no_fire");
    end
    send(8'h1C); expect_now(0, 0, 0, 1, 8'h1C, "paused_left");
    send(8'hF0); send(8'h29); expect_now(0, 0, 0, 1, 8'h1C, "paused_fire_break");
    send(8'h4D); expect_now(1, 0, 0, 0, 8'h4D, "pause_off_left_held");
    idle(1);     expect_now(1, 0, 0, 0, 8'h4D, "unpaused_no_fire");
    send(8'hF0); send(8'h1C); expect_now(0, 0, 0, 0, 8'h4D, "left_break2");
    send(8'hF0); send(8'h4D); expect_now(0, 0, 0, 0, 8'h4D, "pause_break2");

    // Prefix timeout: strobe on the timeout cycle still decodes as extended
    send(8'hE0); idle(7);
    send(8'h74); expect_now(0, 1, 0, 0, 8'hF4, "ext_right_at_timeout");
    send(8'hE0); send(8'hF0); send(8'h74);
    expect_now(0, 0, 0, 0, 8'hF4, "ext_right_break");
    // One cycle later the prefix has expired: plain 74 is ignored
    send(8'hE0); idle(8);
    send(8'h74); expect_now(0, 0, 0, 0, 8'h74, "prefix_timed_out");
    idle(1);     expect_now(0, 0, 0, 0, 8'h74, "prefix_timed_out_hold");

    // Reset mid-sequence discards the prefix
    send(8'hE0);
    reset = 1'b1;
    idle(1);     expect_now(0, 0, 0, 0, 8'h00, "reset_mid_seq");
    reset = 1'b0;
    send(8'h6B); expect_now(0, 0, 0, 0, 8'h6B, "after_reset_plain");
    send(8'hE0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'hF0); send(8'h6B); expect_now(0, 0, 0, 0, 8'h00, "reset_then_break");
    send(8'h6B); expect_now(0, 0, 0, 0, 8'h6B, "idle_after_break");

    idle(3);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_game_input_ctrl.md
PS2_GAME_INPUT_CTRL -- requirements
Module: ps2_game_input_ctrl

Interface
REQ-001 Parameter KEY_LEFT, default 8'h1C, scan code for the plain left key (A).
REQ-002 Parameter KEY_RIGHT, default 8'h23, scan code for the plain right key (D).
REQ-003 Parameter KEY_FIRE, default 8'h29, scan code for the fire key (space).
REQ-004 Parameter KEY_PAUSE, default 8'h4D, scan code for the pause key (P).
REQ-005 Parameter FIRE_GAP, default 5000000, minimum number of cycles between fire pulses (0.1 s at 50 MHz); SHALL be at least 2.
REQ-006 Parameter PREFIX_TIMEOUT, default 50000, number of idle cycles after which a pending prefix is abandoned.
REQ-007 clock  input  1  system clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 ps2_key_pressed  input  1  one-cycle strobe marking a new byte on ps2_key_data.
REQ-010 ps2_key_data  input  8  received PS2 byte; valid only when ps2_key_pressed is 1.
REQ-011 move_left  output  1  level; left key held.
REQ-012 move_right  output  1  level; right key held.
REQ-013 fire  output  1  one-cycle pulse for each granted shot.
REQ-014 pause  output  1  level; game paused.
REQ-015 last_code  output  8  most recent completed make code; bit 7 is forced to 1 for extended keys.

Function
REQ-016 The decoder SHALL be an FSM with four states: IDLE, EXT (8'hE0 seen), BRK (8'hF0 seen), and EXT_BRK (E0 then F0 seen).
REQ-017 Byte transitions SHALL be as follows:
- IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a plain make and returns to IDLE.
- EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is an extended make and goes to IDLE.
- BRK: any byte is a plain break and goes to IDLE.
- EXT_BRK: any byte is an extended break and goes to IDLE.
REQ-018 Key mapping SHALL be: left = plain KEY_LEFT or extended 8'h6B; right = plain KEY_RIGHT or extended 8'h74; fire = plain KEY_FIRE only; pause = plain KEY_PAUSE only; all other codes are ignored apart from last_code.
REQ-019 Held flags (left_src_plain, left_src_ext, right_src_plain, right_src_ext, fire_held, pause_held) SHALL each set on make and clear on break, one cycle after the strobe.
REQ-020 move_left SHALL equal the OR of both left sources, and move_right the OR of both right sources; they are registered outputs, so the latency is 1 cycle after the completing strobe.
REQ-021 If both move_left and move_right would be 1, both outputs SHALL be driven to 0 while the underlying held flags are kept.
REQ-022 A typematic repeat (make while the key is already held) SHALL leave all held flags unchanged and SHALL NOT toggle pause or issue a fire pulse.
REQ-023 pause SHALL toggle on a pause make only when pause_held was 0; a pause break SHALL only clear pause_held.
REQ-024 A cooldown counter of width clog2(FIRE_GAP)+1 SHALL load FIRE_GAP-1 when fire pulses and decrement to 0, saturating at 0.
REQ-025 fire SHALL pulse for 1 cycle when fire_held is 1, the cooldown is 0, and pause is 0; a fresh make therefore fires 1 cycle after held is set, and a held key fires every FIRE_GAP cycles.
REQ-026 While pause is 1, fire SHALL be 0 and move_left/move_right SHALL be forced to 0; held flags SHALL continue to track the keys.
REQ-027 A prefix-timeout counter SHALL run in EXT, BRK, and EXT_BRK, reset on each strobe, and return the FSM to IDLE without side effects on reaching PREFIX_TIMEOUT.
REQ-028 A strobe arriving in the same cycle as a timeout SHALL be decoded in the current (pre-timeout) state.
REQ-029 ps2_key_data SHALL be ignored whenever ps2_key_pressed is 0.

Reset
REQ-030 Asserting reset SHALL immediately set the FSM to IDLE and clear all held flags, both counters, move_left, move_right, fire, pause, and last_code (8'h00).
REQ-031 Reset asserted in mid-sequence (e.g. after E0) SHALL discard the prefix, so the next byte is decoded from IDLE.

Verification (FIRE_GAP=4, PREFIX_TIMEOUT=8)
REQ-032 Strobe 1C, then F0 and 1C -> move_left=1 one cycle after the first strobe, and 0 one cycle after the final 1C; last_code=8'h1C.
REQ-033 Strobe E0 6B, then strobe 23 -> move_left=1, then both outputs=0 after 23 (conflict); after F0 23, move_left returns to 1; last_code=8'hEB after E0 6B.
REQ-034 Strobe 29 and hold for 12 cycles -> fire pulses 1 cycle after held is set and then every 4 cycles (3 pulses); F0 29 -> no further pulses.
REQ-035 Strobe 4D, 4D, F0 4D, 4D -> pause goes 1, 1, 1, 0; while paused, a held fire key yields no pulses and a 1C make gives move_left=0.
REQ-036 Strobe E0, then wait 8 cycles, then strobe 74 -> treated as a plain 74 (ignored), move_right stays 0; separately, E0 followed by reset followed by F0 -> FSM in BRK, not EXT_BRK.
